// File: rtl/bus_initiator_pkg.sv
// Shared definitions for the stb/we/ack peripheral bus: data width, initiator
// state encoding, the master-side control signal set and a timer sizing helper.
package bus_initiator_pkg;

    localparam int BUS_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } bus_state_e;

    typedef struct packed {
        logic stb;
        logic we;
    } bus_ctl_t;

    // Timer bits needed to count 0..t; at least one bit so t == 0 still elaborates.
    function automatic int tmr_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/bus_timeout.sv
// Load/enable counter that raises o_expire on the last permitted cycle.
// TIMEOUT == 0 disables expiry entirely.
module bus_timeout
    import bus_initiator_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TW      = tmr_width(TIMEOUT)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [TW-1:0] LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    assign o_expire = (TIMEOUT != 0) && (cnt_q == LAST);

    // Counting stops at LAST, so the counter never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load)
            cnt_d = '0;
        else if (i_en && !o_expire && (TIMEOUT != 0))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bus_initiator.sv
// Single-outstanding stb/we/ack bus master: accept one command, strobe the bus
// until ack or timeout, then hold the response until it is consumed.
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int AW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_we,
    input  logic [AW-1:0]     i_cmd_adr,
    input  logic [BUS_DW-1:0] i_cmd_dat,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [BUS_DW-1:0] o_rsp_dat,
    output logic              o_rsp_err,
    output logic              o_stb,
    output logic              o_we,
    output logic [AW-1:0]     o_adr,
    output logic [BUS_DW-1:0] o_dat_w,
    input  logic [BUS_DW-1:0] i_dat_r,
    input  logic              i_ack
);

    bus_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [AW-1:0]     adr_q, adr_d;
    logic [BUS_DW-1:0] wdat_q, wdat_d;
    logic [BUS_DW-1:0] rdat_q, rdat_d;
    logic              err_q, err_d;
    logic              tmr_load, tmr_en, tmr_expire;
    bus_ctl_t          ctl;

    bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (tmr_load),
        .i_en     (tmr_en),
        .o_expire (tmr_expire)
    );

    // Every output comes from state or a register; i_ack only steers next state.
    assign ctl         = '{stb: (state_q == ST_BUS), we: we_q};
    assign o_stb       = ctl.stb;
    assign o_we        = ctl.we;
    assign o_adr       = adr_q;
    assign o_dat_w     = wdat_q;
    assign o_cmd_ready = (state_q == ST_IDLE);
    assign o_rsp_valid = (state_q == ST_RSP);
    assign o_rsp_dat   = rdat_q;
    assign o_rsp_err   = err_q;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        rdat_d   = rdat_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    we_d     = i_cmd_we;
                    adr_d    = i_cmd_adr;
                    wdat_d   = i_cmd_dat;
                    tmr_load = 1'b1;
                    state_d  = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ack is checked first so it wins in the timeout cycle.
                if (i_ack) begin
                    rdat_d  = we_q ? '0 : i_dat_r;
                    err_d   = 1'b0;
                    state_d = ST_RSP;
                end else if (tmr_expire) begin
                    rdat_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RSP;
                end else begin
                    tmr_en  = 1'b1;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
        end
    end

endmodule
